out_port_bank: RTL and testbench



---
 rtl/out_port_pkg.sv | 42 ++++
 rtl/out_port_fifo.sv | 93 +++++++++
 rtl/out_port_bank.sv | 85 ++++++++
 tb/tb_out_port_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// out_port_pkg: shared width helpers, parameter legality checks and the
// per-channel FIFO operation encoding used by the output-port bank.
package out_port_pkg;

    // Operation applied to one channel FIFO at a clock edge ({push, pop}).
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Channel-select width: max(1, clog2(channels)).
    function automatic int selw_f(input int channels);
        if (channels <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(channels);
        end
    endfunction

    // Pointer width for a power-of-two FIFO depth (natural wrap).
    function automatic int ptr_w_f(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter width: one extra bit so that count == depth fits.
    function automatic int cnt_w_f(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // Depth must be a power of two and at least 2.
    function automatic bit depth_ok_f(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

    // At least one channel is required.
    function automatic bit channels_ok_f(input int channels);
        return (channels >= 32'sd1);
    endfunction

endpackage

// File: rtl/out_port_fifo.sv
// out_port_fifo: one output channel. DEPTH-entry FIFO with registered
// pointers/count; pushes to a full FIFO are dropped and flagged on overflow.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             overflow
);

    localparam int PW = ptr_w_f(DEPTH);
    localparam int CW = cnt_w_f(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    fifo_op_e         op_s;

    // Flags come straight from the registered count, so valid never
    // depends combinationally on the consumer's ready.
    assign valid = (count_r != {CW{1'b0}});
    assign full  = (count_r == DEPTH_C);

    // Qualify push/pop against pre-edge flags and classify the operation.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & valid;
        overflow  = push & full;
        if (push_ok_s && pop_ok_s) begin
            op_s = FIFO_BOTH;
        end else if (push_ok_s) begin
            op_s = FIFO_PUSH;
        end else if (pop_ok_s) begin
            op_s = FIFO_POP;
        end else begin
            op_s = FIFO_IDLE;
        end
    end

    // Head entry is presented only while the FIFO holds data.
    always_comb begin
        if (valid) begin
            dout = mem_r[rd_ptr_r];
        end else begin
            dout = {WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy update; reset discards everything buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case (op_s)
                FIFO_PUSH: count_r <= count_r + CNT_ONE;
                FIFO_POP:  count_r <= count_r - CNT_ONE;
                default:   count_r <= count_r;
            endcase
        end
    end

    // Storage write; memory contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/out_port_bank.sv
// out_port_bank: CHANNELS buffered output ports written from the data bus.
// Decodes sel, generates the combinational CPU stall and, when
// OUT_PORT_STICKY_ERR_EN is defined, a sticky per-channel overflow flag (err).
module out_port_bank
    import out_port_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int SELW    = selw_f(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [SELW-1:0]           sel,
    input  logic [WIDTH-1:0]          in,
    output logic                      stall,
    output logic [CHANNELS-1:0]       full,
    output logic [CHANNELS*WIDTH-1:0] oport_data,
    output logic [CHANNELS-1:0]       oport_valid,
    input  logic [CHANNELS-1:0]       oport_ready
`ifdef OUT_PORT_STICKY_ERR_EN
    ,
    output logic [CHANNELS-1:0]       err
`endif
);

    localparam bit PARAMS_OK = depth_ok_f(DEPTH) && channels_ok_f(CHANNELS);

    if (!PARAMS_OK) begin : g_bad_params
        $error("out_port_bank: DEPTH must be a power of two >= 2 and CHANNELS >= 1");
    end

    logic [CHANNELS-1:0] push_s;
    logic [CHANNELS-1:0] overflow_s;

    // Select decode: an out-of-range sel matches no channel, so the write
    // is ignored and can neither stall nor raise an error.
    always_comb begin
        push_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (en && (sel == SELW'(c))) begin
                push_s[c] = 1'b1;
            end else begin
                push_s[c] = 1'b0;
            end
        end
    end

    // A push aimed at a full channel is exactly the stall condition.
    assign stall = |overflow_s;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        out_port_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_s[g]),
            .din      (in),
            .pop      (oport_ready[g]),
            .dout     (oport_data[g*WIDTH +: WIDTH]),
            .valid    (oport_valid[g]),
            .full     (full[g]),
            .overflow (overflow_s[g])
        );
    end

`ifdef OUT_PORT_STICKY_ERR_EN
    logic [CHANNELS-1:0] err_r;

    // Sticky overflow record; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= {CHANNELS{1'b0}};
        end else begin
            err_r <= err_r | overflow_s;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// tb_out_port_bank: directed and randomized stimulus on a 2-channel and a
// 3-channel bank, checked against queue-based reference models.
module tb_out_port_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  din;
    logic        sel_a;
    logic [1:0]  sel_b;
    logic [1:0]  rdy_a;
    logic [2:0]  rdy_b;

    logic        stall_a, stall_b;
    logic [1:0]  full_a, valid_a, err_a;
    logic [2:0]  full_b, valid_b, err_b;
    logic [15:0] data_a;
    logic [23:0] data_b;

    always #5 clk = ~clk;

    out_port_bank #(.WIDTH(8), .CHANNELS(2), .DEPTH(4)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .sel(sel_a), .in(din),
        .stall(stall_a), .full(full_a), .oport_data(data_a),
        .oport_valid(valid_a), .oport_ready(rdy_a)
`ifdef OUT_PORT_STICKY_ERR_EN
        , .err(err_a)
`endif
    );

    out_port_bank #(.WIDTH(8), .CHANNELS(3), .DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .sel(sel_b), .in(din),
        .stall(stall_b), .full(full_b), .oport_data(data_b),
        .oport_valid(valid_b), .oport_ready(rdy_b)
`ifdef OUT_PORT_STICKY_ERR_EN
        , .err(err_b)
`endif
    );

`ifndef OUT_PORT_STICKY_ERR_EN
    assign err_a = 2'b00;
    assign err_b = 3'b000;
`endif

    // Reference model: one queue per channel per bank, plus sticky errors.
    typedef logic [7:0] byte_q_t[$];
    byte_q_t    mq [2][3];
    logic [2:0] merr [2];

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int dsel(input int d);
        return (d == 0) ? int'(sel_a) : int'(sel_b);
    endfunction

    function automatic logic [2:0] dready(input int d);
        return (d == 0) ? {1'b0, rdy_a} : rdy_b;
    endfunction

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [23:0] edata;
            logic [2:0]  evalid;
            logic [2:0]  efull;
            logic        estall;
            int          s;
            edata  = '0;
            evalid = '0;
            efull  = '0;
            estall = 1'b0;
            for (int c = 0; c < nch(d); c++) begin
                if (mq[d][c].size() > 0) begin
                    evalid[c] = 1'b1;
                    edata[c*8 +: 8] = mq[d][c][0];
                end
                efull[c] = (mq[d][c].size() == 4);
            end
            s = dsel(d);
            if (en && s < nch(d)) begin
                estall = (mq[d][s].size() == 4);
            end
            if (d == 0) begin
                check("a_valid", valid_a, evalid[1:0]);
                check("a_data",  data_a,  edata[15:0]);
                check("a_full",  full_a,  efull[1:0]);
                check("a_stall", stall_a, estall);
                check("a_err",   err_a,   merr[0][1:0]);
            end else begin
                check("b_valid", valid_b, evalid);
                check("b_data",  data_b,  edata);
                check("b_full",  full_b,  efull);
                check("b_stall", stall_b, estall);
                check("b_err",   err_b,   merr[1]);
            end
        end
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [2:0] r;
            r = dready(d);
            for (int c = 0; c < nch(d); c++) begin
                bit hit, was_full, do_pop;
                hit      = en && (dsel(d) == c);
                was_full = (mq[d][c].size() == 4);
                do_pop   = (mq[d][c].size() > 0) && r[c];
`ifdef OUT_PORT_STICKY_ERR_EN
                if (hit && was_full) merr[d][c] = 1'b1;
`endif
                if (do_pop) void'(mq[d][c].pop_front());
                if (hit && !was_full) mq[d][c].push_back(din);
            end
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            merr[d] = 3'b000;
            for (int c = 0; c < 3; c++) mq[d][c].delete();
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input logic e, input int sa, input int sb, input logic [7:0] v,
                         input logic [2:0] ra, input logic [2:0] rb);
        en    = e;
        sel_a = sa[0];
        sel_b = sb[1:0];
        din   = v;
        rdy_a = ra[1:0];
        rdy_b = rb;
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0; din = 8'h00; sel_a = 1'b0; sel_b = 2'b00; rdy_a = 2'b00; rdy_b = 3'b000;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single push to channel 0, then inspect the next cycle.
        cycle(1'b1, 0, 0, 8'hA5, 3'b000, 3'b000);
        #1;
        check("t1_valid", valid_a, 2'b01);
        check("t1_data0", data_a[7:0], 8'hA5);
        check("t1_data1", data_a[15:8], 8'h00);

        // Fill channel 1, overflow it, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1, 1, 8'(i), 3'b000, 3'b000);
        #1;
        check("t2_full1", full_a[1], 1'b1);
        cycle(1'b1, 1, 1, 8'h05, 3'b000, 3'b000);
`ifdef OUT_PORT_STICKY_ERR_EN
        #1;
        check("t2_err1", err_a[1], 1'b1);
`endif
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("t2_drain", data_a[15:8], 8'(i));
            cycle(1'b0, 0, 0, 8'h00, 3'b010, 3'b010);
        end

        // Channel 0 at two entries: simultaneous push and pop.
        cycle(1'b1, 0, 0, 8'h11, 3'b000, 3'b000);
        cycle(1'b1, 0, 0, 8'h22, 3'b001, 3'b001);
        #1;
        check("t3_head", data_a[7:0], 8'h11);

        // Channel 0 full: pop proceeds, push is dropped.
        cycle(1'b1, 0, 0, 8'h33, 3'b000, 3'b000);
        cycle(1'b1, 0, 0, 8'h44, 3'b000, 3'b000);
        cycle(1'b1, 0, 0, 8'h55, 3'b001, 3'b001);
        #1;
        check("t4_notfull", full_a[0], 1'b0);
        check("t4_head", data_a[7:0], 8'h22);

        // Out-of-range select on the 3-channel bank.
        cycle(1'b1, 1, 3, 8'h66, 3'b000, 3'b000);
        #1;
        check("t5_stall_b", stall_b, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 3),
                  8'($urandom), 3'($urandom), 3'($urandom));
        end

        // Make both banks non-empty with a full channel, then reset between edges.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1, 8'(8'hC0 + i), 3'b000, 3'b000);
        cycle(1'b1, 0, 0, 8'hD0, 3'b000, 3'b000);
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid_a", valid_a, 2'b00);
        check("rst_full_a",  full_a,  2'b00);
        check("rst_err_a",   err_a,   2'b00);
        check("rst_valid_b", valid_b, 3'b000);
        check("rst_full_b",  full_b,  3'b000);
        check("rst_data_a",  data_a,  16'h0000);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 0, 0, 8'h00, 3'b000, 3'b000);
        cycle(1'b1, 1, 2, 8'h77, 3'b000, 3'b000);
        cycle(1'b0, 0, 0, 8'h00, 3'b111, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
